// File: rtl/mips_multicycle_core.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_core
//  Purpose  : Multi-cycle MIPS-I subset core (add/sub/and/or/slt, addi, lw,
//             sw, beq, j) with one shared ALU and one unified req/ack memory
//             port that tolerates wait-stated memory.
//  Ports    : globalclock/globalreset - clock, async active-high reset
//             mem_req/mem_we/mem_addr/mem_wdata - registered request side
//             mem_rdata/mem_ack - memory response
//             retire - 1-cycle pulse per completed instruction
//             halted - sticky illegal-instruction halt
//             isZero - zero flag of the last EXEC ALU result
//             pc_out - address of the next fetch
//  Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              globalclock,
    input  logic              globalreset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic              halted,
    output logic              isZero,
    output logic [31:0]       pc_out
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [2:0]  state, next_state;
    logic [31:0] pc, pc_next, ir, a, b, alu_out, mdr, exec_result;
    logic [31:0] regs [32];
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wb_addr;
    logic [31:0] imm_sext, wb_data;
    logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, is_illegal;
    logic        xfer_done, issue_fetch;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};

    assign is_rtype   = (opcode == OP_RTYPE) &&
                        (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    assign is_addi    = (opcode == OP_ADDI);
    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_j       = (opcode == OP_J);
    assign is_illegal = !(is_rtype || is_addi || is_lw || is_sw || is_beq || is_j);

    // A transfer only counts while a request is outstanding; stray acks are ignored.
    assign xfer_done = mem_req & mem_ack;

    assign wb_addr = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr : alu_out;
    assign pc_out  = pc;

    // Shared ALU: R-type ops, address/immediate add, and A-B for beq's zero flag.
    always_comb begin
        exec_result = a + imm_sext;
        if (is_rtype) begin
            case (funct)
                FN_SUB:  exec_result = a - b;
                FN_AND:  exec_result = a & b;
                FN_OR:   exec_result = a | b;
                FN_SLT:  exec_result = {31'd0, ($signed(a) < $signed(b))};
                default: exec_result = a + b;
            endcase
        end else if (is_beq) begin
            exec_result = a - b;
        end
    end

    always_comb begin
        pc_next = pc;
        if (state == S_FETCH && xfer_done) begin
            pc_next = pc + 32'd4;
        end else if (state == S_EXEC && is_beq && (a == b)) begin
            pc_next = alu_out;
        end else if (state == S_EXEC && is_j) begin
            pc_next = {pc[31:28], ir[25:0], 2'b00};
        end
    end

    // State register
    always_ff @(posedge globalclock or posedge globalreset) begin
        if (globalreset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  if (xfer_done) next_state = S_DECODE;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (is_rtype || is_addi)  next_state = S_WB;
                else if (is_lw || is_sw)  next_state = S_MEM;
                else if (is_beq || is_j)  next_state = S_FETCH;
                else if (HALT_ON_ILLEGAL) next_state = S_HALT;
                else                      next_state = S_FETCH;
            end
            S_MEM:    if (xfer_done) next_state = is_lw ? S_WB : S_FETCH;
            S_WB:     next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        retire = 1'b0;
        halted = 1'b0;
        case (state)
            S_EXEC:  retire = is_beq || is_j || (is_illegal && !HALT_ON_ILLEGAL);
            S_MEM:   retire = xfer_done && is_sw;
            S_WB:    retire = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // The fetch request is raised on the edge that enters FETCH so a zero-wait
    // fetch completes in one cycle. Only the first cycle after reset enters
    // FETCH with no request pending, which is handled by the !mem_req term.
    assign issue_fetch = (next_state == S_FETCH) && ((state != S_FETCH) || !mem_req);

    // Datapath and memory-port registers
    always_ff @(posedge globalclock or posedge globalreset) begin
        if (globalreset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            isZero    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc <= pc_next;

            if (xfer_done) begin
                mem_req <= 1'b0;
            end
            if (issue_fetch) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc_next[ADDR_W-1:0];
            end else if (state == S_EXEC && next_state == S_MEM) begin
                mem_req   <= 1'b1;
                mem_we    <= is_sw;
                mem_addr  <= exec_result[ADDR_W-1:0];
                mem_wdata <= b;
            end

            case (state)
                S_FETCH: begin
                    if (xfer_done) ir <= mem_rdata;
                end
                S_DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= pc + {imm_sext[29:0], 2'b00};
                end
                S_EXEC: begin
                    if (is_rtype || is_addi || is_lw || is_sw) alu_out <= exec_result;
                    if (is_rtype || is_addi || is_lw || is_sw || is_beq)
                        isZero <= (exec_result == 32'd0);
                end
                S_MEM: begin
                    if (xfer_done && is_lw) mdr <= mem_rdata;
                end
                S_WB: begin
                    if (wb_addr != 5'd0) regs[wb_addr] <= wb_data;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mips_multicycle_core
//  Purpose  : Directed self-checking bench for mips_multicycle_core with a
//             wait-state-programmable memory model and a second core
//             instance configured to retire illegal instructions as NOPs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_req, mem_we, ack_model, stray_ack, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        retire, halted, is_zero;
    logic [31:0] pc_out;

    logic        req2, we2, retire2, halted2, zero2;
    logic [31:0] addr2, wdata2, rdata2, pc2;

    assign mem_ack = ack_model | stray_ack;

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
        .globalclock(clk), .globalreset(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .retire(retire), .halted(halted), .isZero(is_zero), .pc_out(pc_out)
    );

    mips_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .globalclock(clk), .globalreset(rst),
        .mem_req(req2), .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2),
        .mem_rdata(rdata2), .mem_ack(req2),
        .retire(retire2), .halted(halted2), .isZero(zero2), .pc_out(pc2)
    );

    // Zero-wait read-only memory for the second core
    logic [31:0] mem2 [16];
    assign rdata2 = mem2[addr2[5:2]];

    // Main memory model state
    logic [31:0] prog [128];
    logic [31:0] mem  [128];
    int load_gen = 0, load_seen = 0, wr_gen = 0, wr_seen = 0;
    int wait_n = 0, wcnt = 0;
    int cyc = 0, ret_cnt = 0, ret2_cnt = 0, req_cyc_cnt = 0, wr_cnt = 0, last_ret_cyc = 0;
    int stab_bad = 0;
    logic [31:0] last_wr_addr = '0, last_wr_data = '0;
    logic        pend = 1'b0, h_we = 1'b0;
    logic [31:0] h_addr = '0, h_wdata = '0;

    int checks = 0, failures = 0;

    // Edge-side bookkeeping: samples the pre-edge values of DUT outputs
    always @(posedge clk) begin
        cyc++;
        if (retire) begin
            ret_cnt++;
            last_ret_cyc = cyc;
        end
        if (retire2) ret2_cnt++;
        if (mem_req) req_cyc_cnt++;
        if (mem_req && mem_ack && mem_we) begin
            wr_cnt++;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            wr_gen++;
        end
        if (mem_req && !mem_ack) begin
            pend    = 1'b1;
            h_addr  = mem_addr;
            h_we    = mem_we;
            h_wdata = mem_wdata;
        end else begin
            pend = 1'b0;
        end
    end

    // Memory responder: owns mem[], drives ack/rdata on the falling edge
    always @(negedge clk) begin
        if (load_gen != load_seen) begin
            for (int i = 0; i < 128; i++) mem[i] = prog[i];
            load_seen = load_gen;
        end
        if (wr_gen != wr_seen) begin
            mem[last_wr_addr[8:2]] = last_wr_data;
            wr_seen = wr_gen;
        end
        if (pend && mem_req &&
            (mem_addr != h_addr || mem_we != h_we || mem_wdata != h_wdata)) stab_bad++;
        if (ack_model) wcnt = 0;
        if (!mem_req) begin
            ack_model = 1'b0;
            wcnt      = 0;
        end else if (wcnt >= wait_n) begin
            ack_model = 1'b1;
            mem_rdata = mem[mem_addr[8:2]];
        end else begin
            ack_model = 1'b0;
            wcnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    endtask

    // Called at a falling edge; program must already be in prog[]
    task automatic apply_reset();
        rst = 1'b1;
        load_gen++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ret(input int target, input string tag);
        int n = 0;
        while (ret_cnt < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (ret_cnt < target) check({tag, "_timeout"}, ret_cnt, target);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!halted) check({tag, "_timeout"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) check({tag, "_timeout"}, {31'd0, mem_req}, 32'd1);
    endtask

    int r0, r2, q0, wr0, sb0, first_edge;

    initial begin
        rst       = 1'b1;
        stray_ack = 1'b0;
        ack_model = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) mem2[i] = 32'h0;
        mem2[0] = 32'hFC00_0000;
        mem2[1] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
        @(negedge clk);

        // T1: async reset in the middle of a wait-stated fetch
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd0);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd5);
        wait_n  = 3;
        apply_reset();
        r0 = ret_cnt;
        wait_ret(r0 + 1, "t1_ret");
        check("t1_pre_req", {31'd0, mem_req}, 32'd1);
        check("t1_pre_zero", {31'd0, is_zero}, 32'd1);
        check("t1_pre_pc", pc_out, 32'h4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_req_async", {31'd0, mem_req}, 32'd0);
        check("t1_zero", {31'd0, is_zero}, 32'd0);
        check("t1_pc", pc_out, 32'h0);
        check("t1_addr", mem_addr, 32'h0);
        check("t1_we_wdata", {mem_we, retire, halted, mem_wdata[28:0]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_req("t1_req");
        check("t1_first_addr", mem_addr, 32'h0);

        // T2: zero-wait ALU program, CPI and retire count
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        prog[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        prog[3] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        wait_n  = 0;
        @(negedge clk);
        apply_reset();
        r0 = ret_cnt;
        wait_req("t2_req");
        first_edge = cyc + 1;
        wait_halt("t2_halt");
        check("t2_retires", ret_cnt - r0, 32'd4);
        check("t2_cycles", last_ret_cyc - first_edge, 32'd15);
        check("t2_r2", dut.regs[2], 32'hFFFF_FFFD);
        check("t2_r3", dut.regs[3], 32'h2);
        check("t2_r4", dut.regs[4], 32'h1);
        check("t2_pc", pc_out, 32'h14);

        // T3: three wait states on every transfer; sw then lw
        clear_prog();
        prog[0]  = enc_j(26'h10);
        prog[16] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        prog[17] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        prog[18] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
        wait_n   = 3;
        @(negedge clk);
        apply_reset();
        wr0 = wr_cnt;
        sb0 = stab_bad;
        wait_halt("t3_halt");
        check("t3_writes", wr_cnt - wr0, 32'd1);
        check("t3_wr_addr", last_wr_addr, 32'h8);
        check("t3_wr_data", last_wr_data, 32'h2);
        check("t3_r5", dut.regs[5], 32'h2);
        check("t3_stable", stab_bad - sb0, 32'd0);

        // T4a: taken beq back onto itself
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
        wait_n  = 0;
        @(negedge clk);
        apply_reset();
        r0 = ret_cnt;
        wait_ret(r0 + 3, "t4_beq");
        check("t4_beq_pc", pc_out, 32'h8);
        check("t4_beq_zero", {31'd0, is_zero}, 32'd1);
        wait_ret(r0 + 4, "t4_beq2");
        check("t4_beq_pc2", pc_out, 32'h8);

        // T4b: not-taken beq then j 0x40
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2] = enc_i(6'h04, 5'd1, 5'd2, 16'd4);
        prog[3] = enc_j(26'h40);
        @(negedge clk);
        apply_reset();
        r0 = ret_cnt;
        wait_ret(r0 + 3, "t4_bne");
        check("t4_bne_pc", pc_out, 32'hC);
        check("t4_bne_zero", {31'd0, is_zero}, 32'd0);
        wait_ret(r0 + 4, "t4_j");
        check("t4_j_pc", pc_out, 32'h100);

        // T5: $0 writes dropped, stray acks ignored
        clear_prog();
        prog[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        prog[1] = enc_r(5'd1, 5'd1, 5'd0, 6'h20);
        prog[2] = enc_i(6'h08, 5'd0, 5'd6, 16'd9);
        prog[3] = enc_r(5'd0, 5'd1, 5'd7, 6'h20);
        @(negedge clk);
        rst = 1'b1;
        load_gen++;
        repeat (2) @(negedge clk);
        stray_ack = 1'b1;
        rst       = 1'b0;
        @(negedge clk);
        stray_ack = 1'b0;
        check("t5_stray_pc", pc_out, 32'h0);
        wait_halt("t5_halt");
        check("t5_r0", dut.regs[0], 32'h0);
        check("t5_r6", dut.regs[6], 32'h9);
        check("t5_r7", dut.regs[7], 32'h3);
        q0 = req_cyc_cnt;
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        check("t5_halt_pc", pc_out, 32'h14);
        check("t5_halt_reqs", req_cyc_cnt - q0, 32'd0);

        // T6: illegal opcode, halting and non-halting configurations
        clear_prog();
        prog[0] = 32'hFC00_0000;
        @(negedge clk);
        apply_reset();
        r0 = ret_cnt;
        r2 = ret2_cnt;
        for (int n = 0; n < 50 && ret2_cnt < r2 + 1; n++) @(negedge clk);
        check("t6_nh_pc", pc2, 32'h4);
        check("t6_nh_halted", {31'd0, halted2}, 32'd0);
        for (int n = 0; n < 50 && ret2_cnt < r2 + 2; n++) @(negedge clk);
        check("t6_nh_r1", dut_nh.regs[1], 32'h7);
        check("t6_nh_pc2", pc2, 32'h8);
        wait_halt("t6_halt");
        q0 = req_cyc_cnt;
        repeat (20) @(negedge clk);
        check("t6_halted", {31'd0, halted}, 32'd1);
        check("t6_no_reqs", req_cyc_cnt - q0, 32'd0);
        check("t6_no_retire", ret_cnt - r0, 32'd0);
        check("t6_pc", pc_out, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
